fir_seq_mac: RTL and testbench

Streaming FIR multiply-accumulate engine that consumes the sample burst produced by the 1024-deep sample queue. While `sequencing` is high it takes one 16-bit sample per cycle. It pairs each sample with a Q1.15 coefficient fetched from an external synchronous coefficient ROM and accumulates the products at full precision. When the burst ends it outputs one saturated 16-bit filtered sample with a single-cycle valid pulse. One instance sits per equalizer band, between the queue and the band-gain/summing stage.

---
 rtl/eq_pkg.sv | 14 +
 rtl/fir_mac_dp.sv | 78 +++++++
 rtl/fir_seq_mac.sv | 120 ++++++++++++
 tb/tb_fir_seq_mac.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// Shared equalizer definitions: tap count default, FIR control states, Q15 scaling.
package eq_pkg;

   localparam int unsigned N_TAPS_DEF = 1021;
   localparam int unsigned Q15_SHIFT  = 15;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } fir_state_t;

endpackage

// File: rtl/fir_mac_dp.sv
// FIR datapath: sample register, 16x16 product register, full-precision accumulator,
// Q15 rescale with saturation into the held output register.
module fir_mac_dp
   import eq_pkg::*;
#(
   parameter int unsigned ACC_W = 42
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        vld_in,
   input  logic [15:0] smpl_in,
   input  logic [15:0] coef_data,
   input  logic        load_out,
   output logic [15:0] filt_out
);

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

   logic signed [15:0]      s1_smpl_q;
   logic                    s1_vld_q;
   logic signed [31:0]      prod_q;
   logic                    s2_vld_q;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_sh;
   logic [15:0]             sat_val;
   logic [15:0]             filt_q;

   // S1/S2 pipeline: the ROM word for a sample arrives the cycle it sits in S1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_smpl_q <= '0;
         s1_vld_q  <= 1'b0;
         prod_q    <= '0;
         s2_vld_q  <= 1'b0;
      end else begin
         s1_vld_q <= vld_in;
         if (vld_in) s1_smpl_q <= smpl_in;
         s2_vld_q <= s1_vld_q;
         if (s1_vld_q) prod_q <= s1_smpl_q * $signed(coef_data);
      end
   end

   // S3 accumulator; clr coincides with sample 0 entering S1, so no product is lost
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (clr) begin
         acc_q <= '0;
      end else if (s2_vld_q) begin
         acc_q <= acc_q + {{(ACC_W-32){prod_q[31]}}, prod_q};
      end
   end

   // Arithmetic shift floors toward minus infinity, then clamp to 16-bit signed
   always_comb begin
      acc_sh  = acc_q >>> Q15_SHIFT;
      sat_val = acc_sh[15:0];
      if (acc_sh > SAT_MAX) begin
         sat_val = 16'h7FFF;
      end else if (acc_sh < SAT_MIN) begin
         sat_val = 16'h8000;
      end
   end

   // Output register holds between bursts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q <= '0;
      end else if (load_out) begin
         filt_q <= sat_val;
      end
   end

   assign filt_out = filt_q;

endmodule

// File: rtl/fir_seq_mac.sv
// Burst-driven FIR MAC: sequences coefficient addresses, detects overrun and
// pulses filt_vld once the pipeline has drained.
module fir_seq_mac
   import eq_pkg::*;
#(
   parameter int unsigned N_TAPS = N_TAPS_DEF,
   parameter int unsigned ACC_W  = 42
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sequencing,
   input  logic [15:0] smpl_in,
   output logic [9:0]  coef_addr,
   input  logic [15:0] coef_data,
   output logic [15:0] filt_out,
   output logic        filt_vld,
   output logic        ovr_err
);

   localparam logic [9:0] LAST_ADDR = 10'(N_TAPS - 1);

   fir_state_t state_q, state_d;
   logic [9:0] addr_q, addr_d;
   logic       full_q, full_d;   // tap N_TAPS-1 already consumed this burst
   logic       ovr_q, ovr_d;
   logic       flush_q, flush_d;
   logic       clr, vld_in, load_out;

   // Control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         full_q  <= 1'b0;
         ovr_q   <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         full_q  <= full_d;
         ovr_q   <= ovr_d;
         flush_q <= flush_d;
      end
   end

   // Next-state, address sequencing and datapath strobes
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      full_d   = full_q;
      ovr_d    = ovr_q;
      flush_d  = flush_q;
      clr      = 1'b0;
      vld_in   = 1'b0;
      load_out = 1'b0;
      unique case (state_q)
         IDLE: begin
            addr_d = '0;
            full_d = 1'b0;
            if (sequencing) begin
               clr     = 1'b1;
               vld_in  = 1'b1;
               ovr_d   = 1'b0;
               state_d = ACCUM;
               if (LAST_ADDR == 10'd0) full_d = 1'b1;
               else                    addr_d = 10'd1;
            end
         end
         ACCUM: begin
            if (sequencing) begin
               if (full_q) begin
                  ovr_d = 1'b1;
               end else begin
                  vld_in = 1'b1;
                  if (addr_q == LAST_ADDR) full_d = 1'b1;
                  else                     addr_d = addr_q + 10'd1;
               end
            end else begin
               state_d = FLUSH;
               addr_d  = '0;
               full_d  = 1'b0;
               flush_d = 1'b0;
            end
         end
         FLUSH: begin
            if (sequencing) ovr_d = 1'b1;
            if (flush_q) begin
               flush_d  = 1'b0;
               load_out = 1'b1;
               state_d  = DONE;
            end else begin
               flush_d = 1'b1;
            end
         end
         DONE: begin
            if (sequencing) ovr_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   fir_mac_dp #(
      .ACC_W(ACC_W)
   ) u_dp (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .vld_in   (vld_in),
      .smpl_in  (smpl_in),
      .coef_data(coef_data),
      .load_out (load_out),
      .filt_out (filt_out)
   );

   assign coef_addr = addr_q;
   assign filt_vld  = (state_q == DONE);
   assign ovr_err   = ovr_q;

endmodule

// File: tb/tb_fir_seq_mac.sv
// Directed bench for fir_seq_mac with a synchronous coefficient ROM model.
module tb_fir_seq_mac;

   localparam int N = 1021;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sequencing;
   logic [15:0] smpl_in;
   logic [9:0]  coef_addr;
   logic [15:0] coef_data;
   logic [15:0] filt_out;
   logic        filt_vld;
   logic        ovr_err;

   logic [15:0] rom [1024];
   logic [9:0]  addr_trace [1100];
   int          n_checks = 0;
   int          n_fail = 0;
   int          vld_count = 0;
   logic [9:0]  max_addr = '0;

   int          vld_cyc, npulse, vlds;
   logic [15:0] res;
   logic        ovr_at_vld;
   logic [9:0]  addr_at_vld;

   fir_seq_mac dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sequencing(sequencing),
      .smpl_in   (smpl_in),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .filt_out  (filt_out),
      .filt_vld  (filt_vld),
      .ovr_err   (ovr_err)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: data for address k is presented the cycle after
   always @(posedge clk) coef_data <= rom[coef_addr];

   always @(negedge clk) begin
      if (filt_vld) vld_count++;
      if (coef_addr > max_addr) max_addr = coef_addr;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic fill_rom(input logic [15:0] v);
      for (int i = 0; i < 1024; i++) rom[i] = v;
   endtask

   // Drives one burst: sample 0 = s0, samples 1..N-1 = s_rest, beyond N = s_over
   task automatic run_burst(input int len, input logic [15:0] s0, input logic [15:0] s_rest,
                            input logic [15:0] s_over);
      int start;
      start   = vld_count;
      vld_cyc = -1;
      res     = '0;
      ovr_at_vld  = 1'bx;
      addr_at_vld = 'x;
      @(posedge clk); #1;
      for (int k = 0; k < len; k++) begin
         sequencing    = 1'b1;
         smpl_in       = (k == 0) ? s0 : (k < N) ? s_rest : s_over;
         addr_trace[k] = coef_addr;
         @(posedge clk); #1;
      end
      sequencing = 1'b0;
      smpl_in    = '0;
      for (int c = len; c < len + 10; c++) begin
         if (filt_vld && vld_cyc < 0) begin
            vld_cyc     = c;
            res         = filt_out;
            ovr_at_vld  = ovr_err;
            addr_at_vld = coef_addr;
         end
         @(posedge clk); #1;
      end
      npulse = vld_count - start;
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n      = 1'b0;
      sequencing = 1'b0;
      smpl_in    = '0;
      fill_rom(16'h0000);
      #12;
      check_eq("rst_addr", 32'(coef_addr), 32'h0);
      check_eq("rst_out", 32'(filt_out), 32'h0);
      check_eq("rst_vld", 32'(filt_vld), 32'h0);
      check_eq("rst_ovr", 32'(ovr_err), 32'h0);
      #10 rst_n = 1'b1;

      // Impulse: 0x7FFF*0x4000 = 536854528, >>15 = 16383
      fill_rom(16'h1234);
      rom[0] = 16'h4000;
      run_burst(N, 16'h7FFF, 16'h0000, 16'h0000);
      check_eq("imp_out", 32'(res), 32'h3FFF);
      check_eq("imp_cyc", 32'(vld_cyc), 32'd1024);
      check_eq("imp_pulses", 32'(npulse), 32'd1);
      check_eq("imp_ovr", 32'(ovr_at_vld), 32'h0);
      check_eq("imp_hold", 32'(filt_out), 32'h3FFF);

      // DC: 256*16*1021 = 4182016, >>15 = 127
      fill_rom(16'h0100);
      run_burst(N, 16'h0010, 16'h0010, 16'h0010);
      check_eq("dc_out", 32'(res), 32'h007F);

      fill_rom(16'h7FFF);
      run_burst(N, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      check_eq("sat_pos", 32'(res), 32'h7FFF);
      run_burst(N, 16'h8000, 16'h8000, 16'h8000);
      check_eq("sat_neg", 32'(res), 32'h8000);

      // Short: 0x1000*0x2000 = 2^25, *10 >>15 = 10240
      fill_rom(16'h2000);
      run_burst(10, 16'h1000, 16'h1000, 16'h0000);
      for (int k = 0; k < 10; k++) check_eq($sformatf("short_addr%0d", k), 32'(addr_trace[k]), 32'(k));
      check_eq("short_out", 32'(res), 32'h2800);
      check_eq("short_cyc", 32'(vld_cyc), 32'd13);
      check_eq("short_addr_done", 32'(addr_at_vld), 32'h0);
      check_eq("short_ovr", 32'(ovr_at_vld), 32'h0);

      // Overrun: trailing 0x7FFF samples and the unused ROM words must not contribute
      fill_rom(16'h0100);
      for (int i = N; i < 1024; i++) rom[i] = 16'h7FFF;
      max_addr = '0;
      run_burst(N + 4, 16'h0010, 16'h0010, 16'h7FFF);
      check_eq("ovr_out", 32'(res), 32'h007F);
      check_eq("ovr_cyc", 32'(vld_cyc), 32'd1028);
      check_eq("ovr_flag", 32'(ovr_at_vld), 32'h1);
      check_eq("ovr_max_addr", 32'(max_addr), 32'd1020);
      check_eq("ovr_addr_hold", 32'(addr_trace[N + 3]), 32'd1020);
      check_eq("ovr_sticky", 32'(ovr_err), 32'h1);
      // 4096*256*10 >>15 = 320; flag cleared by the new burst
      run_burst(10, 16'h1000, 16'h1000, 16'h0000);
      check_eq("ovr_clear", 32'(ovr_at_vld), 32'h0);
      check_eq("ovr_next_out", 32'(res), 32'h0140);

      // Reset in the middle of a burst
      fill_rom(16'h0100);
      @(posedge clk); #1;
      for (int k = 0; k < 500; k++) begin
         sequencing = 1'b1;
         smpl_in    = 16'h0010;
         @(posedge clk); #1;
      end
      smpl_in = 16'h0010;
      #2 rst_n = 1'b0;
      #1;
      check_eq("mid_rst_addr", 32'(coef_addr), 32'h0);
      check_eq("mid_rst_out", 32'(filt_out), 32'h0);
      check_eq("mid_rst_vld", 32'(filt_vld), 32'h0);
      check_eq("mid_rst_ovr", 32'(ovr_err), 32'h0);
      vlds       = vld_count;
      sequencing = 1'b0;
      smpl_in    = '0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      check_eq("mid_rst_no_vld", 32'(vld_count), 32'(vlds));
      run_burst(N, 16'h0010, 16'h0010, 16'h0010);
      check_eq("post_rst_out", 32'(res), 32'h007F);
      check_eq("post_rst_cyc", 32'(vld_cyc), 32'd1024);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
